// File: rtl/bol_emulator.sv
// Bolometer focal-plane emulator.
//   Waits for a rising INT edge, then emits one frame: an integration
//   period, then ROWS lines, each an HBLANK gap followed by COLS active
//   pixels. The pixel pattern is chosen by a 16-bit config word. That
//   word is shifted in MSB first on SERDATA while the emulator is idle.
//
// Ports:
//   CLK        - clock, rising edge
//   RESET      - synchronous reset, active low
//   INT        - frame start request (rising edge)
//   SERDATA    - serial config bit, shifted in every idle clock
//   DATAVALID  - high on each active pixel clock
//   LINE1      - DATAVALID qualified to line 0
//   ERROR      - sticky fault: start while busy, or bad config parity
//   PIX[13:0]  - pixel value, zero when DATAVALID is low
//   FRAME_DONE - one-clock pulse in the clock after the last pixel
//
// Build option: BOLEMU_PARITY_EN adds a 17th config bit (bit 16).
//   That bit carries odd parity over bits [15:0] and is checked at the
//   start edge.
module bol_emulator #(
  parameter int COLS       = 384,
  parameter int ROWS       = 288,
  parameter int INT_CYCLES = 64,
  parameter int HBLANK     = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        INT,
  input  logic        SERDATA,
  output logic        DATAVALID,
  output logic        LINE1,
  output logic        ERROR,
  output logic [13:0] PIX,
  output logic        FRAME_DONE
);

`ifdef BOLEMU_PARITY_EN
  localparam int CFGW = 17;
`else
  localparam int CFGW = 16;
`endif
  localparam int CW   = $clog2(COLS) + 1;
  localparam int RW   = $clog2(ROWS) + 1;
  localparam int TMAX = (INT_CYCLES > HBLANK) ? INT_CYCLES : HBLANK;
  localparam int TW   = $clog2(TMAX) + 1;

  typedef enum logic [1:0] {S_IDLE, S_INTEG, S_BLANK, S_ACTIVE} state_t;

  state_t            r_state, w_nstate;
  logic              r_int_d;
  logic [CFGW-1:0]   r_cfg;
  logic [1:0]        r_mode;
  logic [13:0]       r_seed;
  logic [TW-1:0]     r_tmr;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic              r_error;
  logic              r_frame_done;

  logic              w_start, w_cfg_ok, w_col_last, w_row_last;
  logic [13:0]       w_col14, w_row14, w_pix;

  assign w_start    = INT & ~r_int_d;
`ifdef BOLEMU_PARITY_EN
  // The total number of ones over all 17 bits must be odd.
  assign w_cfg_ok   = ^r_cfg;
`else
  assign w_cfg_ok   = 1'b1;
`endif
  assign w_col_last = (r_col == CW'(COLS - 1));
  assign w_row_last = (r_row == RW'(ROWS - 1));

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:   if (w_start && w_cfg_ok)              w_nstate = S_INTEG;
      S_INTEG:  if (r_tmr == TW'(INT_CYCLES - 1))     w_nstate = S_BLANK;
      S_BLANK:  if (r_tmr == TW'(HBLANK - 1))         w_nstate = S_ACTIVE;
      S_ACTIVE: if (w_col_last) w_nstate = w_row_last ? S_IDLE : S_BLANK;
      default:                                        w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state      <= S_IDLE;
      r_int_d      <= 1'b1;  // INT held high through reset must not start a frame
      r_cfg        <= '0;
      r_mode       <= '0;
      r_seed       <= '0;
      r_tmr        <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_error      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_nstate;
      r_int_d      <= INT;
      r_frame_done <= (r_state == S_ACTIVE) && (w_nstate == S_IDLE);

      if (r_state == S_IDLE)
        r_cfg <= {r_cfg[CFGW-2:0], SERDATA};

      // A start is accepted only when idle with good config. In every
      // other case it only raises the sticky error.
      if (w_start) begin
        if (r_state != S_IDLE || !w_cfg_ok) begin
          r_error <= 1'b1;
        end else begin
          r_mode <= r_cfg[15:14];
          r_seed <= r_cfg[13:0];
          r_col  <= '0;
          r_row  <= '0;
        end
      end

      // Shared phase timer for INTEG and BLANK; restarts on every state change.
      if ((r_state == S_INTEG || r_state == S_BLANK) && w_nstate == r_state)
        r_tmr <= r_tmr + TW'(1);
      else
        r_tmr <= '0;

      if (r_state == S_ACTIVE) begin
        if (w_col_last) begin
          r_col <= '0;
          if (!w_row_last) r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  assign w_col14 = 14'(r_col);
  assign w_row14 = 14'(r_row);

  always_comb begin
    w_pix = r_seed;
    case (r_mode)
      2'd0: w_pix = r_seed;
      2'd1: w_pix = w_col14 + r_seed;
      2'd2: w_pix = w_row14 + r_seed;
      2'd3: w_pix = (r_row[0] ^ r_col[0]) ? 14'h3FFF : 14'h0000;
      default: w_pix = r_seed;
    endcase
  end

  assign DATAVALID  = (r_state == S_ACTIVE);
  assign LINE1      = DATAVALID && (r_row == '0);
  assign PIX        = DATAVALID ? w_pix : 14'h0000;
  assign ERROR      = r_error;
  assign FRAME_DONE = r_frame_done;

endmodule

// File: doc/bol_emulator.md
BOL_EMULATOR -- requirements
Module: bol_emulator

Interface
REQ-001 SHALL have parameter COLS, default 384: active pixels per line.
REQ-002 SHALL have parameter ROWS, default 288: lines per frame.
REQ-003 SHALL have parameter INT_CYCLES, default 64: integration period in clocks.
REQ-004 SHALL have parameter HBLANK, default 16: blanking clocks before every line.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port RESET, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port INT, input, 1 bit: frame start request; a rising edge starts a frame.
REQ-008 SHALL have port SERDATA, input, 1 bit: serial configuration stream, MSB first.
REQ-009 SHALL have port DATAVALID, output, 1 bit: high on each active pixel clock.
REQ-010 SHALL have port LINE1, output, 1 bit: high with DATAVALID during line 0 only.
REQ-011 SHALL have port ERROR, output, 1 bit: sticky fault flag.
REQ-012 SHALL have port PIX, output, 14 bits: pixel value, qualified by DATAVALID.
REQ-013 SHALL have port FRAME_DONE, output, 1 bit: one-clock pulse after the last pixel.

Function
REQ-014 SHALL register INT once (INT_d) and detect a start edge when INT=1 and INT_d=0.
REQ-015 SHALL shift SERDATA into a config shift register on every clock while in IDLE, and hold the register in every other state.
REQ-016 SHALL, on a start edge in IDLE, latch the config register: bits[15:14] set MODE and bits[13:0] set SEED.
REQ-017 SHALL implement states IDLE, INTEG, BLANK and ACTIVE.
REQ-018 SHALL make these transitions:
  - IDLE->INTEG on a start edge.
  - INTEG->BLANK after INT_CYCLES clocks.
  - BLANK->ACTIVE after HBLANK clocks.
  - ACTIVE->BLANK after COLS clocks when row<ROWS-1.
  - ACTIVE->IDLE after COLS clocks when row=ROWS-1.
REQ-019 SHALL time the frame so that, if the start edge is sampled at edge k, the first DATAVALID goes high after edge k+INT_CYCLES+HBLANK.
REQ-020 SHALL drive DATAVALID=1 for exactly COLS consecutive clocks per line and ROWS lines per frame.
REQ-021 SHALL drive PIX=0 whenever DATAVALID=0.
REQ-022 SHALL generate PIX by MODE, with 14-bit wrap-around on all sums:
  - MODE 0: PIX=SEED.
  - MODE 1: PIX=col+SEED.
  - MODE 2: PIX=row+SEED.
  - MODE 3: PIX=3FFFh when row[0]^col[0]=1, else 0.
REQ-023 SHALL use col 0..COLS-1 and row 0..ROWS-1 counters that reset to 0 at frame start; col also resets to 0 at each line start.
REQ-024 SHALL pulse FRAME_DONE high for the one clock immediately after the final ACTIVE clock, coincident with the return to IDLE.
REQ-025 SHALL, on a start edge outside IDLE, set ERROR, ignore the edge, and continue the current frame unaltered.
REQ-026 SHALL treat INT held high as a single edge; it SHALL start no further frames until INT returns low.
REQ-027 SHALL accept a start edge in the same clock that FRAME_DONE is asserted, because the state is IDLE in that clock.

Reset
REQ-028 SHALL, while RESET=0 at a rising CLK edge, force:
  - state=IDLE; col, row and MODE/SEED to 0.
  - config register to 0.
  - INT_d=1, so that INT held high through reset release does not start a frame.
  - DATAVALID, LINE1, ERROR, FRAME_DONE and PIX to 0.
REQ-029 SHALL, on reset mid-frame, abort the frame immediately with no FRAME_DONE pulse.
REQ-030 SHALL clear ERROR only by reset.

Configuration
REQ-031 SHALL, when macro BOLEMU_PARITY_EN is defined, use a 17-bit config register whose bit 16 is odd parity over bits[15:0].
REQ-032 SHALL, with BOLEMU_PARITY_EN defined and a parity mismatch at a start edge, set ERROR, stay in IDLE, and leave MODE/SEED unchanged.
REQ-033 SHALL, without BOLEMU_PARITY_EN, use a 16-bit register with no parity check; in that build a parity fault SHALL never set ERROR.

Verification (COLS=4, ROWS=2, INT_CYCLES=3, HBLANK=2)
REQ-034 Shift 0x4005 (MODE 1, SEED 5), then raise INT -> first DATAVALID 5 clocks after the edge; PIX per line = 5,6,7,8; LINE1 high on line 0 only; FRAME_DONE pulses once; 8 DATAVALID clocks total.
REQ-035 MODE 3 frame -> line 0 PIX = 0,3FFFh,0,3FFFh; line 1 PIX = 3FFFh,0,3FFFh,0.
REQ-036 MODE 1, SEED 3FFEh -> PIX = 3FFEh,3FFFh,0,1 (wrap-around).
REQ-037 Second INT rising edge during BLANK of line 1 -> ERROR=1 and stays 1; frame completes with 8 valid pixels; no second frame starts.
REQ-038 RESET low for one clock during ACTIVE of line 0 -> all outputs 0 on the next clock, no FRAME_DONE; INT held high across reset release -> no frame starts.
REQ-039 With BOLEMU_PARITY_EN, shift 17 bits with wrong parity and raise INT -> ERROR=1, DATAVALID stays 0; with correct parity -> frame runs normally.
